register_file_mp: RTL

Parametrised multi-port register file for the MIPS datapath, successor to the single-write, two-read register file. Configurable data width, register count, and read/write port counts. Provides same-cycle write-to-read bypass, plus a per-register busy scoreboard that the decode stage uses to detect RAW hazards against in-flight producers. Sits between decode (reads, issue) and writeback (writes).

---
 rtl/cpu_types_pkg.sv | 10 +
 rtl/register_file_mp_if.sv | 31 +++
 rtl/register_file_mp_scoreboard.sv | 50 +++++
 rtl/register_file_mp.sv | 75 +++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the MIPS core: machine word and register-file index.
package cpu_types_pkg;

    localparam int RF_NREGS = 32;
    localparam int RF_AW    = $clog2(RF_NREGS);

    typedef logic [31:0]       word_t;
    typedef logic [RF_AW-1:0]  rf_idx_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Bundle of register-file port arrays; rf side is the storage, tb side drives it.
interface register_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input logic CLK
);
    logic                             RST;
    logic [NWRITE-1:0]                wen;
    logic [NWRITE-1:0][AW-1:0]        wsel;
    logic [NWRITE-1:0][DATA_W-1:0]    wdat;
    logic [NREAD-1:0][AW-1:0]         rsel;
    logic [NREAD-1:0][DATA_W-1:0]     rdat;
    logic [NREAD-1:0]                 rbusy;
    logic                             iss_en;
    logic [AW-1:0]                    iss_sel;
    logic                             flush;

    modport rf (
        input  CLK, RST, wen, wsel, wdat, rsel, iss_en, iss_sel, flush,
        output rdat, rbusy
    );

    modport tb (
        input  CLK, rdat, rbusy,
        output RST, wen, wsel, wdat, rsel, iss_en, iss_sel, flush
    );
endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush/reset wipe all.
module rf_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      i_flush,
    input  logic                      i_iss_en,
    input  logic [AW-1:0]             i_iss_sel,
    input  logic [NWRITE-1:0]         i_wen,
    input  logic [NWRITE-1:0][AW-1:0] i_wsel,
    input  logic [NREAD-1:0][AW-1:0]  i_rsel,
    input  logic [NREAD-1:0]          i_hit,
    output logic [NREAD-1:0]          o_rbusy
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Writeback clears first so a same-cycle issue to the same register overrides it.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NWRITE; i++) begin
            if (i_wen[i]) w_busy_nxt[i_wsel[i]] = 1'b0;
        end
        if (i_iss_en) w_busy_nxt[i_iss_sel] = 1'b1;
        if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A register being written back this cycle is already resolved for the reader.
    always_comb begin
        o_rbusy = '0;
        for (int j = 0; j < NREAD; j++) begin
            o_rbusy[j] = r_busy[i_rsel[j]] & ~i_hit[j];
        end
    end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port MIPS register file with same-cycle write bypass and RAW busy scoreboard.
module register_file_mp
    import cpu_types_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NREGS    = RF_NREGS,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NWRITE-1:0]             wen,
    input  logic [NWRITE-1:0][AW-1:0]     wsel,
    input  logic [NWRITE-1:0][DATA_W-1:0] wdat,
    input  logic [NREAD-1:0][AW-1:0]      rsel,
    output logic [NREAD-1:0][DATA_W-1:0]  rdat,
    output logic [NREAD-1:0]              rbusy,
    input  logic                          iss_en,
    input  logic [AW-1:0]                 iss_sel,
    input  logic                          flush
);
    logic [NREGS-1:0][DATA_W-1:0] r_mem;
    logic [NREAD-1:0]             w_hit;

    // Later ports are applied last, so the highest-numbered port wins a collision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mem <= '0;
        end else begin
            for (int i = 0; i < NWRITE; i++) begin
                if (wen[i] && !(ZERO_REG != 0 && wsel[i] == '0)) begin
                    r_mem[wsel[i]] <= wdat[i];
                end
            end
        end
    end

    always_comb begin
        rdat  = '0;
        w_hit = '0;
        for (int j = 0; j < NREAD; j++) begin
            rdat[j] = r_mem[rsel[j]];
            for (int i = 0; i < NWRITE; i++) begin
                if (wen[i] && wsel[i] == rsel[j]) begin
                    w_hit[j] = 1'b1;
                    rdat[j]  = wdat[i];
                end
            end
            if (ZERO_REG != 0 && rsel[j] == '0) begin
                w_hit[j] = 1'b0;
                rdat[j]  = '0;
            end
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST       (RST),
        .i_flush   (flush),
        .i_iss_en  (iss_en),
        .i_iss_sel (iss_sel),
        .i_wen     (wen),
        .i_wsel    (wsel),
        .i_rsel    (rsel),
        .i_hit     (w_hit),
        .o_rbusy   (rbusy)
    );
endmodule
